// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle for wb_stage: pipeline control, MEM-stage operands,
// and the register-file write / forwarding results.
interface wb_stage_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            flush;
   logic            mem_valid;
   logic            mem_reg_write;
   logic [4:0]      mem_rd;
   logic [1:0]      mem_wb_sel;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_pc_plus4;
   logic [XLEN-1:0] mem_load_data;
   logic [2:0]      mem_funct3;

   logic            wb_en;
   logic [4:0]      rd_index;
   logic [XLEN-1:0] wb_data;
   logic            fwd_valid;
   logic [4:0]      fwd_rd;
   logic [XLEN-1:0] fwd_data;
   logic            retire;

   modport master (
      output stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
             mem_alu_result, mem_pc_plus4, mem_load_data, mem_funct3,
      input  wb_en, rd_index, wb_data, fwd_valid, fwd_rd, fwd_data, retire
   );

   modport slave (
      input  stall, flush, mem_valid, mem_reg_write, mem_rd, mem_wb_sel,
             mem_alu_result, mem_pc_plus4, mem_load_data, mem_funct3,
      output wb_en, rd_index, wb_data, fwd_valid, fwd_rd, fwd_data, retire
   );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with result select and load alignment.
// Optional retired-instruction counter output instret under `WB_RETIRE_CNT_EN.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   wb_stage_if.slave        wb
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [CNT_W-1:0] instret
`endif
);

   logic signed [XLEN-1:0] sel_p0;
   logic                   vld_p1;
   logic                   reg_write_p1;
   logic [4:0]             rd_p1;
   logic signed [XLEN-1:0] data_p1;

   // Undefined funct3 codes fall back to a full-word load.
   function automatic logic signed [XLEN-1:0] align_load(
      input logic [XLEN-1:0] word,
      input logic [1:0]      off,
      input logic [2:0]      f3
   );
      logic signed [7:0]  b;
      logic signed [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  align_load = {{(XLEN-8){b[7]}}, b};
         3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
         3'b001:  align_load = {{(XLEN-16){h[15]}}, h};
         3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
         default: align_load = word;
      endcase
   endfunction

   // Stage p0: result selection from MEM operands
   always_comb begin
      sel_p0 = wb.mem_alu_result;
      case (wb.mem_wb_sel)
         2'b01:   sel_p0 = align_load(wb.mem_load_data, wb.mem_alu_result[1:0],
                                      wb.mem_funct3);
         2'b10:   sel_p0 = wb.mem_pc_plus4;
         default: sel_p0 = wb.mem_alu_result;
      endcase
   end

   // Stage p1: WB register; flush outranks stall
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1       <= 1'b0;
         reg_write_p1 <= 1'b0;
         rd_p1        <= 5'd0;
         data_p1      <= '0;
      end else if (wb.flush) begin
         vld_p1       <= 1'b0;
         reg_write_p1 <= 1'b0;
         rd_p1        <= 5'd0;
         data_p1      <= '0;
      end else if (!wb.stall) begin
         vld_p1       <= wb.mem_valid;
         reg_write_p1 <= wb.mem_reg_write;
         rd_p1        <= wb.mem_rd;
         data_p1      <= sel_p0;
      end
   end

   assign wb.wb_en     = vld_p1 & reg_write_p1 & (rd_p1 != 5'd0);
   assign wb.rd_index  = rd_p1;
   assign wb.wb_data   = data_p1;
   assign wb.fwd_valid = wb.wb_en;
   assign wb.fwd_rd    = rd_p1;
   assign wb.fwd_data  = data_p1;
   // The instruction leaves WB on any edge that is not a stall, flush included.
   assign wb.retire    = vld_p1 & ~wb.stall;

`ifdef WB_RETIRE_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instret <= '0;
      else if (wb.retire)
         instret <= instret + 1'b1;
   end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for selection/alignment plus
// hand sequences for stall/flush and asynchronous reset.
module tb_wb_stage;

   localparam logic [31:0] LD = 32'h80FF_7F01;

   typedef struct {
      logic        v;
      logic        rw;
      logic [4:0]  rd;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [2:0]  f3;
      logic        en;
      logic [31:0] data;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   wb_stage_if #(.XLEN(32)) bus ();

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] instret;
   wb_stage #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .wb(bus), .instret(instret)
   );
`else
   wb_stage #(.XLEN(32), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .wb(bus)
   );
`endif

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic en, input logic [4:0] rd,
                          input logic [31:0] data, input logic ret);
      chk({tag, " wb_en"},     64'(bus.wb_en),     64'(en));
      chk({tag, " rd_index"},  64'(bus.rd_index),  64'(rd));
      chk({tag, " wb_data"},   64'(bus.wb_data),   64'(data));
      chk({tag, " fwd_valid"}, 64'(bus.fwd_valid), 64'(en));
      chk({tag, " fwd_rd"},    64'(bus.fwd_rd),    64'(rd));
      chk({tag, " fwd_data"},  64'(bus.fwd_data),  64'(data));
      chk({tag, " retire"},    64'(bus.retire),    64'(ret));
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [2:0] f3);
      bus.mem_valid      = v;
      bus.mem_reg_write  = rw;
      bus.mem_rd         = rd;
      bus.mem_wb_sel     = sel;
      bus.mem_alu_result = alu;
      bus.mem_pc_plus4   = pc4;
      bus.mem_load_data  = LD;
      bus.mem_funct3     = f3;
   endtask

   function automatic vec_t mk(input logic v, input logic rw, input logic [4:0] rd,
                               input logic [1:0] sel, input logic [31:0] alu,
                               input logic [31:0] pc4, input logic [2:0] f3,
                               input logic en, input logic [31:0] data);
      vec_t t;
      t.v = v; t.rw = rw; t.rd = rd; t.sel = sel; t.alu = alu;
      t.pc4 = pc4; t.f3 = f3; t.en = en; t.data = data;
      return t;
   endfunction

   vec_t tbl[16];

   initial begin
      tbl[0]  = mk(1, 1, 5'd5,  2'b00, 32'h0000_1234, 32'h0,     3'b000, 1, 32'h0000_1234);
      tbl[1]  = mk(1, 1, 5'd10, 2'b01, 32'h0000_1002, 32'h0,     3'b000, 1, 32'hFFFF_FFFF);
      tbl[2]  = mk(1, 1, 5'd10, 2'b01, 32'h0000_1003, 32'h0,     3'b100, 1, 32'h0000_0080);
      tbl[3]  = mk(1, 1, 5'd11, 2'b01, 32'h0000_1002, 32'h0,     3'b001, 1, 32'hFFFF_80FF);
      tbl[4]  = mk(1, 1, 5'd11, 2'b01, 32'h0000_1000, 32'h0,     3'b101, 1, 32'h0000_7F01);
      tbl[5]  = mk(1, 1, 5'd12, 2'b01, 32'h0000_1003, 32'h0,     3'b010, 1, 32'h80FF_7F01);
      tbl[6]  = mk(1, 1, 5'd12, 2'b01, 32'h0000_1001, 32'h0,     3'b000, 1, 32'h0000_007F);
      tbl[7]  = mk(1, 1, 5'd13, 2'b01, 32'h0000_1003, 32'h0,     3'b001, 1, 32'hFFFF_80FF);
      tbl[8]  = mk(1, 1, 5'd13, 2'b01, 32'h0000_1001, 32'h0,     3'b111, 1, 32'h80FF_7F01);
      tbl[9]  = mk(1, 1, 5'd14, 2'b01, 32'h0000_1000, 32'h0,     3'b000, 1, 32'h0000_0001);
      tbl[10] = mk(1, 1, 5'd0,  2'b00, 32'hDEAD_BEEF, 32'h0,     3'b000, 0, 32'hDEAD_BEEF);
      tbl[11] = mk(1, 1, 5'd1,  2'b10, 32'h0000_5555, 32'h0104, 3'b000, 1, 32'h0000_0104);
      tbl[12] = mk(1, 1, 5'd2,  2'b11, 32'hCAFE_0001, 32'h0104, 3'b000, 1, 32'hCAFE_0001);
      tbl[13] = mk(1, 0, 5'd3,  2'b00, 32'h0000_0033, 32'h0,     3'b000, 0, 32'h0000_0033);
      tbl[14] = mk(0, 1, 5'd4,  2'b00, 32'h0000_0044, 32'h0,     3'b000, 0, 32'h0000_0044);
      tbl[15] = mk(1, 1, 5'd31, 2'b01, 32'h0000_1001, 32'h0,     3'b101, 1, 32'h0000_7F01);

      // Reset state, observed before any clock edge
      rst_n     = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(1, 1, 5'd9, 2'b00, 32'h0000_0999, 32'h0, 3'b000);
      #3;
      chk_out("reset", 0, 5'd0, 32'h0, 0);
`ifdef WB_RETIRE_CNT_EN
      chk("reset instret", instret, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].rw, tbl[i].rd, tbl[i].sel, tbl[i].alu, tbl[i].pc4, tbl[i].f3);
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].rd, tbl[i].data, tbl[i].v);
      end

      // Stall for three edges, then flush on release, then flush+stall
      drive(1, 1, 5'd7, 2'b00, 32'h0000_0011, 32'h0, 3'b000);
      @(negedge clk);
      chk_out("stall c0", 1, 5'd7, 32'h11, 1);
      bus.stall = 1'b1;
      drive(1, 1, 5'd9, 2'b00, 32'h0000_0099, 32'h0, 3'b000);
      #1;
      chk_out("stall c1", 1, 5'd7, 32'h11, 0);
      for (int k = 2; k <= 3; k++) begin
         @(negedge clk);
         chk_out($sformatf("stall c%0d", k), 1, 5'd7, 32'h11, 0);
      end
      @(negedge clk);
      bus.stall = 1'b0;
      #1;
      chk_out("stall release", 1, 5'd7, 32'h11, 1);
      @(negedge clk);
      chk_out("after stall", 1, 5'd9, 32'h99, 1);
      bus.flush = 1'b1;
      #1;
      chk("flush retire", 64'(bus.retire), 64'd1);
      bus.stall = 1'b1;
      #1;
      chk("flush+stall retire", 64'(bus.retire), 64'd0);
      @(negedge clk);
      chk_out("flush bubble", 0, 5'd0, 32'h0, 0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // Clean count, five back-to-back retires, then async reset mid-cycle
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive(1, 1, 5'(20 + k), 2'b00, 32'(32'h100 + k), 32'h0, 3'b000);
         @(negedge clk);
      end
      chk_out("pre-reset", 1, 5'd25, 32'h105, 1);
`ifdef WB_RETIRE_CNT_EN
      chk("instret 5", instret, 64'd5);
`endif
      drive(1, 1, 5'd12, 2'b00, 32'h0000_0077, 32'h0, 3'b000);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async reset", 0, 5'd0, 32'h0, 0);
`ifdef WB_RETIRE_CNT_EN
      chk("async instret", instret, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_out("post-reset", 1, 5'd12, 32'h77, 1);
`ifdef WB_RETIRE_CNT_EN
      chk("post-reset instret", instret, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
